// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, keeps at most one I-cache request outstanding and buffers {pc, inst} in a 2-entry queue.
// Optional stall-cycle counter is built when IF_STALL_CNT_EN is defined; otherwise o_stall_cycles reads 0.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned Q_DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_jb,
  input  logic [31:0] i_jb_target,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic [31:0] o_inst_out,
  output logic [31:0] o_current_pc_out,
  output logic        o_stall_cache,
  output logic [31:0] o_stall_cycles
);

  localparam logic [1:0]  Q_FULL = 2'(Q_DEPTH);
  localparam logic [31:0] NOP    = 32'd19;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_pc;
  logic [31:0] r_q_pc   [2];
  logic [31:0] r_q_inst [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_req_valid;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_tail;

  assign w_req_valid = !i_rst && (r_state == ST_ISSUE) && (r_count < Q_FULL);
  assign w_accept    = w_req_valid && i_imem_req_ready;
  // A response only becomes a queue entry when it is not overtaken by a redirect.
  assign w_push      = !i_rst && (r_state == ST_WAIT) && i_imem_resp_valid && !i_jb;
  assign w_pop       = (r_count != 2'd0) && !i_stall && !i_jb;
  assign w_tail      = r_head ^ r_count[0];

  // Next-state and next-PC selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = i_jb ? i_jb_target : r_pc;
    case (r_state)
      ST_ISSUE: begin
        if (w_accept) begin
          w_state_nxt = i_jb ? ST_DRAIN : ST_WAIT;
          w_pc_nxt    = i_jb ? i_jb_target : (r_pc + 32'd4);
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (i_imem_resp_valid) begin
          w_state_nxt = ST_ISSUE;
        end else if (i_jb) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (i_imem_resp_valid) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_ISSUE;
      end
    endcase
  end

  // Control state: FSM, PC, request PC and queue pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_ISSUE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_accept) begin
        r_req_pc <= r_pc;
      end
      if (i_jb) begin
        r_head  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_pop) begin
          r_head <= ~r_head;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  // Queue storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_pc[w_tail]   <= r_req_pc;
      r_q_inst[w_tail] <= i_imem_resp_data;
    end
  end

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_stall_cache    = (r_count == 2'd0);
  assign o_inst_out       = (r_count == 2'd0) ? NOP   : r_q_inst[r_head];
  assign o_current_pc_out = (r_count == 2'd0) ? 32'd0 : r_q_pc[r_head];

`ifdef IF_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Free-running count of cycles with an empty queue
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= 32'd0;
    end else if (r_count == 2'd0) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized traffic against a
// transaction-level model (PC, outstanding-request flag, queue of {pc, inst}).
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, jb, ready, resp_valid;
  logic [31:0] jbt, resp_data;
  logic        o_req_valid, o_stall_cache;
  logic [31:0] o_req_addr, o_inst, o_pc, o_scyc;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .Q_DEPTH(2)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_jb             (jb),
    .i_jb_target      (jbt),
    .o_imem_req_valid (o_req_valid),
    .o_imem_req_addr  (o_req_addr),
    .i_imem_req_ready (ready),
    .i_imem_resp_valid(resp_valid),
    .i_imem_resp_data (resp_data),
    .o_inst_out       (o_inst),
    .o_current_pc_out (o_pc),
    .o_stall_cache    (o_stall_cache),
    .o_stall_cycles   (o_scyc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc, m_scnt;
  bit          m_out, m_stale;
  // I-cache model state
  bit          c_pend;
  logic [31:0] c_addr;
  int          c_cnt;
  // per-cycle stimulus knobs
  bit          t_rst, t_stall, t_jb, t_ready;
  logic [31:0] t_jbt;
  int          t_lat;
  int          checks = 0, failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    bit          m_valid, acc, resp, acc_dut;
    logic [31:0] exp_inst, exp_pc;
    @(negedge clk);
    rst = t_rst; stall = t_stall; jb = t_jb; jbt = t_jbt; ready = t_ready;
    resp = 1'b0;
    if (c_pend && !t_rst) begin
      c_cnt--;
      if (c_cnt <= 0) resp = 1'b1;
    end
    resp_valid = resp;
    resp_data  = resp ? mem_word(c_addr) : $urandom;
    #1;
    m_valid = !t_rst && !m_out && (mq.size() < 2);
    if (mq.size() != 0) begin
      exp_inst = mq[0].inst;
      exp_pc   = mq[0].pc;
    end else begin
      exp_inst = 32'd19;
      exp_pc   = 32'd0;
    end
    check_val("req_valid", {31'd0, o_req_valid}, {31'd0, m_valid});
    if (m_valid) check_val("req_addr", o_req_addr, m_pc);
    check_val("inst_out", o_inst, exp_inst);
    check_val("current_pc", o_pc, exp_pc);
    check_val("stall_cache", {31'd0, o_stall_cache}, {31'd0, (mq.size() == 0)});
`ifdef IF_STALL_CNT_EN
    check_val("stall_cycles", o_scyc, m_scnt);
`else
    check_val("stall_cycles", o_scyc, 32'd0);
`endif
    // I-cache: one request at a time, answered after t_lat cycles
    acc_dut = o_req_valid && t_ready;
    if (t_rst) begin
      c_pend = 1'b0;
    end else begin
      if (resp) c_pend = 1'b0;
      if (acc_dut) begin
        c_pend = 1'b1;
        c_addr = o_req_addr;
        c_cnt  = t_lat;
      end
    end
    // reference model update for the coming edge
    acc = m_valid && t_ready;
    if (t_rst) begin
      mq.delete();
      m_pc = RESET_PC; m_out = 1'b0; m_stale = 1'b0; m_scnt = 32'd0;
    end else begin
      if (mq.size() == 0) m_scnt = m_scnt + 32'd1;
      if (t_jb) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && !t_stall) void'(mq.pop_front());
        if (resp && m_out && !m_stale) mq.push_back('{m_req_pc, mem_word(m_req_pc)});
      end
      if (resp) m_out = 1'b0;
      if (t_jb && m_out) m_stale = 1'b1;
      if (acc) begin
        m_out = 1'b1; m_stale = t_jb; m_req_pc = m_pc;
      end
      m_pc = t_jb ? t_jbt : (acc ? m_pc + 32'd4 : m_pc);
    end
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    t_jb = 1'b0; t_stall = 1'b0; t_ready = 1'b1;
    while (!(m_out && !m_stale && c_pend && c_cnt == t_lat) && n < 20) begin
      cycle();
      n++;
    end
    check_val(tag, {31'd0, (n < 20)}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jb = 1'b0; jbt = 32'd0; ready = 1'b0;
    resp_valid = 1'b0; resp_data = 32'd0;
    repeat (2) @(posedge clk);
    mq.delete();
    m_pc = RESET_PC; m_req_pc = RESET_PC; m_scnt = 32'd0; m_out = 1'b0; m_stale = 1'b0;
    c_pend = 1'b0; c_addr = 32'd0; c_cnt = 0;
    t_rst = 1'b1; t_stall = 1'b0; t_jb = 1'b0; t_jbt = 32'd0; t_ready = 1'b1; t_lat = 1;

    cycle();                                   // reset-state outputs
    t_rst = 1'b0;
    repeat (12) cycle();                       // 1-cycle cache streaming
    t_stall = 1'b1; repeat (6) cycle();        // queue fills, head holds
    t_stall = 1'b0; repeat (6) cycle();
    t_ready = 1'b0; repeat (3) cycle();        // request held while not accepted
    t_ready = 1'b1; repeat (4) cycle();

    t_lat = 2; wait_accept("acc_for_jb_wait");
    t_jb = 1'b1; t_jbt = 32'h0000_0100; cycle();   // redirect in WAIT, late response dropped
    t_jb = 1'b0; repeat (8) cycle();

    t_lat = 1; wait_accept("acc_for_jb_resp");
    t_jb = 1'b1; t_jbt = 32'h0000_0200; cycle();   // redirect coincident with response
    t_jb = 1'b0; repeat (6) cycle();

    t_lat = 3; wait_accept("acc_for_rst");
    t_rst = 1'b1; cycle();                     // reset while waiting
    t_rst = 1'b0; t_lat = 1; repeat (6) cycle();

    t_jb = 1'b1; t_jbt = 32'hFFFF_FFF8; cycle();   // PC wrap
    t_jb = 1'b0; repeat (8) cycle();

    for (int i = 0; i < 4000; i++) begin
      t_rst   = ($urandom_range(0, 299) == 0);
      t_stall = ($urandom_range(0, 3) == 0);
      t_jb    = ($urandom_range(0, 11) == 0);
      t_jbt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      t_ready = ($urandom_range(0, 3) != 0);
      t_lat   = $urandom_range(1, 3);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
